cmd_seg_display: RTL and testbench

//  Multi-digit, time-multiplexed 7-segment driver for the calculator front panel.

---
 rtl/cmd_seg_pkg.sv | 65 ++++++
 rtl/seg_hex_decode.sv | 9 +
 rtl/cmd_seg_display.sv | 119 +++++++++++
 tb/tb_cmd_seg_display.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/cmd_seg_pkg.sv
// Glyph tables and the hex font for the calculator front-panel display.
// Segment order is bit6..0 = g,f,e,d,c,b,a, active low.
package cmd_seg_pkg;

    localparam logic [2:0] CMD_LD = 3'd0;
    localparam logic [2:0] CMD_AD = 3'd1;
    localparam logic [2:0] CMD_SU = 3'd2;
    localparam logic [2:0] CMD_AN = 3'd3;
    localparam logic [2:0] CMD_OR = 3'd4;
    localparam logic [2:0] CMD_SH = 3'd5;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] GLY_DASH  = 7'b0111111;

    localparam logic [6:0] GLY_LD_HI = 7'b1000111;
    localparam logic [6:0] GLY_LD_LO = 7'b0100001;
    localparam logic [6:0] GLY_AD_HI = 7'b0001000;
    localparam logic [6:0] GLY_AD_LO = 7'b0100001;
    localparam logic [6:0] GLY_SU_HI = 7'b0010010;
    localparam logic [6:0] GLY_SU_LO = 7'b1100011;
    localparam logic [6:0] GLY_AN_HI = 7'b0001000;
    localparam logic [6:0] GLY_AN_LO = 7'b0101011;
    localparam logic [6:0] GLY_OR_HI = 7'b1000000;
    localparam logic [6:0] GLY_OR_LO = 7'b0101111;
    localparam logic [6:0] GLY_SH_HI = 7'b0010010;
    localparam logic [6:0] GLY_SH_LO = 7'b0001011;

    function automatic logic [6:0] seg_hex(input logic [3:0] nib);
        seg_hex = SEG_BLANK;
        case (nib)
            4'h0: seg_hex = 7'b1000000;
            4'h1: seg_hex = 7'b1111001;
            4'h2: seg_hex = 7'b0100100;
            4'h3: seg_hex = 7'b0110000;
            4'h4: seg_hex = 7'b0011001;
            4'h5: seg_hex = 7'b0010010;
            4'h6: seg_hex = 7'b0000010;
            4'h7: seg_hex = 7'b1111000;
            4'h8: seg_hex = 7'b0000000;
            4'h9: seg_hex = 7'b0010000;
            4'hA: seg_hex = 7'b0001000;
            4'hB: seg_hex = 7'b0000011;
            4'hC: seg_hex = 7'b1000110;
            4'hD: seg_hex = 7'b0100001;
            4'hE: seg_hex = 7'b0000110;
            4'hF: seg_hex = 7'b0001110;
            default: seg_hex = SEG_BLANK;
        endcase
    endfunction

    // hi selects the leftmost mnemonic digit; codes 110/111 show "--"
    function automatic logic [6:0] mnem_glyph(input logic [2:0] cmd, input logic hi);
        mnem_glyph = GLY_DASH;
        case (cmd)
            CMD_LD: mnem_glyph = hi ? GLY_LD_HI : GLY_LD_LO;
            CMD_AD: mnem_glyph = hi ? GLY_AD_HI : GLY_AD_LO;
            CMD_SU: mnem_glyph = hi ? GLY_SU_HI : GLY_SU_LO;
            CMD_AN: mnem_glyph = hi ? GLY_AN_HI : GLY_AN_LO;
            CMD_OR: mnem_glyph = hi ? GLY_OR_HI : GLY_OR_LO;
            CMD_SH: mnem_glyph = hi ? GLY_SH_HI : GLY_SH_LO;
            default: mnem_glyph = GLY_DASH;
        endcase
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to 7-segment (active-low) decoder.
module seg_hex_decode
    import cmd_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = seg_hex(nibble);
endmodule

// File: rtl/cmd_seg_display.sv
// Time-multiplexed 7-segment driver: command mnemonic on the two left digits,
// latched hex operand on the rest. Define SEG_BLINK_EN to blink the "--" mnemonic.
module cmd_seg_display
    import cmd_seg_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      LOAD,
    input  logic [2:0]                CMD,
    input  logic [4*(N_DIGITS-2)-1:0] DATA,
    output logic [6:0]                SEG,
    output logic [N_DIGITS-1:0]       AN
);
    localparam int DW = $clog2(N_DIGITS);
    localparam int CW = $clog2(SCAN_DIV);

    if (N_DIGITS < 3 || SCAN_DIV < 2 || BLINK_FRAMES < 1) begin : g_bad_param
        $error("cmd_seg_display: illegal parameter set");
    end

    logic [2:0]                cmd_q;
    logic [4*(N_DIGITS-2)-1:0] data_q;
    logic [CW-1:0]             scan_cnt;
    logic [DW-1:0]             dig_idx;
    logic                      slot_end;
    logic                      mnem_hidden;
    logic [3:0]                nib;
    logic [6:0]                hex_seg;
    logic [6:0]                glyph;
    logic [N_DIGITS-1:0]       an_sel;

    assign slot_end = (scan_cnt == CW'(SCAN_DIV - 1));

    always_comb begin
        nib = '0;
        for (int k = 0; k < N_DIGITS - 2; k++)
            if (dig_idx == DW'(k)) nib = data_q[4*k +: 4];
    end

    seg_hex_decode u_hex (
        .nibble (nib),
        .seg    (hex_seg)
    );

    always_comb begin
        glyph = hex_seg;
        if (dig_idx == DW'(N_DIGITS - 1))
            glyph = mnem_hidden ? SEG_BLANK : mnem_glyph(cmd_q, 1'b1);
        else if (dig_idx == DW'(N_DIGITS - 2))
            glyph = mnem_hidden ? SEG_BLANK : mnem_glyph(cmd_q, 1'b0);
        an_sel = '1;
        an_sel[dig_idx] = 1'b0;
    end

    // Slot cycle 0 is forced blank so the previous digit never ghosts into the next.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cmd_q    <= 3'b111;
            data_q   <= '0;
            scan_cnt <= '0;
            dig_idx  <= '0;
            SEG      <= SEG_BLANK;
            AN       <= '1;
        end else begin
            if (LOAD) begin
                cmd_q  <= CMD;
                data_q <= DATA;
            end
            if (slot_end) begin
                scan_cnt <= '0;
                dig_idx  <= (dig_idx == DW'(N_DIGITS - 1)) ? '0 : dig_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            if (scan_cnt == '0) begin
                SEG <= SEG_BLANK;
                AN  <= '1;
            end else begin
                SEG <= glyph;
                AN  <= an_sel;
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [FW-1:0] frame_cnt;
    logic          hidden;
    logic          frame_end;

    assign frame_end   = slot_end && (dig_idx == DW'(N_DIGITS - 1));
    assign mnem_hidden = hidden && (cmd_q[2:1] == 2'b11);

    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_cnt <= '0;
            hidden    <= 1'b0;
        end else if (LOAD && CMD <= CMD_SH) begin
            frame_cnt <= '0;
            hidden    <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                hidden    <= ~hidden;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`else
    assign mnem_hidden = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_seg_display.sv
// Directed bench for cmd_seg_display with N_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
module tb_cmd_seg_display;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       LOAD = 1'b0;
    logic [2:0] CMD = 3'b000;
    logic [7:0] DATA = 8'h00;
    logic [6:0] SEG;
    logic [3:0] AN;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [6:0] g [4];
    int         drv [4];
    int         blanks;
    int         bad;

    always #5 CLK = ~CLK;

    cmd_seg_display #(.N_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .LOAD (LOAD),
        .CMD  (CMD),
        .DATA (DATA),
        .SEG  (SEG),
        .AN   (AN)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // cyc counts edges since reset release; state before edge e+1 is scan=e%4, dig=(e/4)%4
    task automatic tick();
        @(posedge CLK);
        #1;
        if (RST) cyc = 0;
        else     cyc++;
    endtask

    task automatic grab_frame();
        logic prev_blank;
        prev_blank = 1'b0;
        blanks = 0;
        bad    = 0;
        for (int d = 0; d < 4; d++) begin
            g[d]   = 7'h7F;
            drv[d] = 0;
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            if (AN === 4'hF) begin
                blanks++;
                if (SEG !== 7'h7F) bad++;
                if (prev_blank) bad++;
                prev_blank = 1'b1;
            end else begin
                prev_blank = 1'b0;
                if ($countones(~AN) != 1) bad++;
                else
                    for (int d = 0; d < 4; d++)
                        if (AN[d] == 1'b0) begin
                            if (drv[d] > 0 && SEG !== g[d]) bad++;
                            g[d] = SEG;
                            drv[d]++;
                        end
            end
        end
        for (int d = 0; d < 4; d++)
            if (drv[d] != 3) bad++;
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 32 && (cyc % 16) != ph; i++) tick();
        chk("align", cyc % 16, ph);
    endtask

    initial begin
        int nfr;
        logic [6:0] exp_m;

        // reset state
        RST = 1'b1;
        repeat (3) tick();
        chk("rst_seg", SEG, 7'h7F);
        chk("rst_an", AN, 4'hF);
        RST = 1'b0;
        tick();
        chk("first_blank_seg", SEG, 7'h7F);
        chk("first_blank_an", AN, 4'hF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("d0_an", AN, 4'hE);
            chk("d0_seg", SEG, 7'b1000000);
        end

        // capture Ad / 0x3A, then one full frame with ghost checks
        LOAD = 1'b1; CMD = 3'b001; DATA = 8'h3A;
        tick();
        LOAD = 1'b0;
        grab_frame();
        chk("cap_d0", g[0], 7'b0001000);
        chk("cap_d1", g[1], 7'b0110000);
        chk("cap_d2", g[2], 7'b0100001);
        chk("cap_d3", g[3], 7'b0001000);
        chk("ghost_blanks", blanks, 4);
        chk("ghost_bad", bad, 0);

        // LOAD on the edge that opens the digit-3 slot
        LOAD = 1'b1; CMD = 3'b011;
        tick();
        LOAD = 1'b0;
        wait_phase(11);
        LOAD = 1'b1; CMD = 3'b100;
        tick();
        LOAD = 1'b0;
        tick();
        chk("wrap_blank_an", AN, 4'hF);
        chk("wrap_blank_seg", SEG, 7'h7F);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wrap_an", AN, 4'h7);
            chk("wrap_seg_O", SEG, 7'b1000000);
        end

        // reset in the middle of the digit-2 slot
        wait_phase(10);
        chk("mid_an", AN, 4'hB);
        RST = 1'b1;
        tick();
        chk("mid_rst_seg", SEG, 7'h7F);
        chk("mid_rst_an", AN, 4'hF);
        RST = 1'b0;

        // "--" frames: blinking with the macro, steady without
`ifdef SEG_BLINK_EN
        nfr = 4;
`else
        nfr = 8;
`endif
        for (int f = 0; f < nfr; f++) begin
            exp_m = 7'b0111111;
`ifdef SEG_BLINK_EN
            if (f == 2 || f == 3) exp_m = 7'h7F;
`endif
            grab_frame();
            chk($sformatf("dash_d3_f%0d", f), g[3], exp_m);
            chk($sformatf("dash_d2_f%0d", f), g[2], exp_m);
            chk($sformatf("dash_d0_f%0d", f), g[0], 7'b1000000);
            chk($sformatf("dash_d1_f%0d", f), g[1], 7'b1000000);
            chk($sformatf("dash_bad_f%0d", f), bad, 0);
        end

        // valid command restores a steady mnemonic
        LOAD = 1'b1; CMD = 3'b000;
        tick();
        LOAD = 1'b0;
        grab_frame();
        chk("ld_d3", g[3], 7'b1000111);
        chk("ld_d2", g[2], 7'b0100001);
        chk("ld_bad", bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
